modexp_seq: RTL and testbench

MODEXP_SEQ -- requirements
Module: modexp_seq

---
 rtl/modexp_seq.sv | 181 ++++++++++++++++++
 tb/tb_modexp_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_seq.sv
// Modular exponentiation sequencer.
// Fetches exponent words from an external RAM, scans the bits MSB-first,
// skips leading zeros, and drives the left-to-right square-and-multiply
// command stream into a modular multiplier. Every command is a one-cycle
// strobe followed by an unbounded wait for the multiplier's ack pulse.
module modexp_seq #(
    parameter int e_words = 4,
    parameter int w_width = 27
) (
    input  logic               clk,
    input  logic               aclr,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               zero_exp,
    output logic [4:0]         e_addr,
    output logic               e_rden,
    input  logic [w_width-1:0] e_datai,
    output logic [2:0]         command,
    input  logic               command_ack
);

    localparam logic [2:0] CMD_NONE    = 3'b000;
    localparam logic [2:0] CMD_PRELOAD = 3'b100;
    localparam logic [2:0] CMD_SQUARE  = 3'b011;
    localparam logic [2:0] CMD_MULT    = 3'b010;
    localparam logic [2:0] CMD_STORE   = 3'b101;

    localparam logic [4:0] TOP_WORD = 5'(e_words - 1);
    localparam logic [4:0] TOP_BIT  = 5'(w_width - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAITDATA,
        SCAN,
        ISSUE,
        WAIT_ACK,
        STORE,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [4:0]         word_reg, word_next;     // also drives e_addr
    logic [4:0]         bit_reg, bit_next;
    logic [w_width-1:0] shift_reg, shift_next;   // current bit always at MSB
    logic               found_reg, found_next;   // leading one already seen
    logic               zero_reg, zero_next;     // exponent turned out all zeros
    logic [2:0]         cmd_reg, cmd_next;       // command in flight
    logic               advance;                 // current bit fully processed
    logic               cur_bit;

    assign cur_bit = shift_reg[w_width-1];
    assign e_addr  = word_reg;

    // State and datapath registers; aclr aborts everything at once.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_reg <= IDLE;
            word_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            found_reg <= 1'b0;
            zero_reg  <= 1'b0;
            cmd_reg   <= CMD_NONE;
        end else begin
            state_reg <= state_next;
            word_reg  <= word_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            found_reg <= found_next;
            zero_reg  <= zero_next;
            cmd_reg   <= cmd_next;
        end
    end

    // Next-state, datapath updates and outputs, all decoded from the state register.
    always_comb begin
        state_next = state_reg;
        word_next  = word_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        found_next = found_reg;
        zero_next  = zero_reg;
        cmd_next   = cmd_reg;
        advance    = 1'b0;
        busy       = (state_reg != IDLE);
        done       = 1'b0;
        zero_exp   = 1'b0;
        e_rden     = 1'b0;
        command    = CMD_NONE;

        case (state_reg)
            IDLE: begin
                found_next = 1'b0;
                zero_next  = 1'b0;
                if (start) begin
                    word_next  = TOP_WORD;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                e_rden     = 1'b1;
                state_next = WAITDATA;
            end
            WAITDATA: begin
                shift_next = e_datai;
                bit_next   = TOP_BIT;
                state_next = SCAN;
            end
            SCAN: begin
                if (!found_reg) begin
                    if (cur_bit) begin
                        // Leading one: seed the accumulator with the base.
                        found_next = 1'b1;
                        cmd_next   = CMD_PRELOAD;
                        state_next = ISSUE;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cmd_next   = CMD_SQUARE;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                command    = cmd_reg;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (command_ack) begin
                    case (cmd_reg)
                        CMD_SQUARE: begin
                            if (cur_bit) begin
                                cmd_next   = CMD_MULT;
                                state_next = ISSUE;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                        CMD_STORE: state_next = DONE;
                        default:   advance = 1'b1;
                    endcase
                end
            end
            STORE: begin
                command    = CMD_STORE;
                cmd_next   = CMD_STORE;
                state_next = WAIT_ACK;
            end
            DONE: begin
                done       = 1'b1;
                zero_exp   = zero_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Step to the next lower bit, the next lower word, or finish.
        if (advance) begin
            if (bit_reg == 5'd0) begin
                if (word_reg == 5'd0) begin
                    if (found_reg) begin
                        state_next = STORE;
                    end else begin
                        zero_next  = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    word_next  = word_reg - 5'd1;
                    state_next = FETCH;
                end
            end else begin
                shift_next = shift_reg << 1;
                bit_next   = bit_reg - 5'd1;
                state_next = SCAN;
            end
        end
    end

endmodule

// File: tb/tb_modexp_seq.sv
// Bench for modexp_seq: directed and random exponents against a
// square-and-multiply reference model of the expected command stream.
module tb_modexp_seq;

    localparam int EW = 4;
    localparam int WW = 27;

    localparam logic [2:0] C_PRE = 3'b100;
    localparam logic [2:0] C_SQR = 3'b011;
    localparam logic [2:0] C_MUL = 3'b010;
    localparam logic [2:0] C_STO = 3'b101;

    logic          clk = 1'b0;
    logic          aclr;
    logic          start;
    logic          busy;
    logic          done;
    logic          zero_exp;
    logic [4:0]    e_addr;
    logic          e_rden;
    logic [WW-1:0] e_datai;
    logic [2:0]    command;
    logic          command_ack;

    logic          auto_ack;
    logic          man_ack;
    logic          ack_en;

    logic [WW-1:0] mem [EW];
    logic [2:0]    cmd_q[$];
    logic [4:0]    rd_q[$];
    logic [2:0]    exp_cmd_q[$];
    logic          exp_zero;

    int total = 0;
    int bad   = 0;

    assign command_ack = auto_ack | man_ack;

    modexp_seq #(.e_words(EW), .w_width(WW)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .zero_exp    (zero_exp),
        .e_addr      (e_addr),
        .e_rden      (e_rden),
        .e_datai     (e_datai),
        .command     (command),
        .command_ack (command_ack)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Exponent RAM: data for a read is presented the cycle after e_rden.
    initial begin
        e_datai = '0;
        forever begin
            @(negedge clk);
            if (e_rden) e_datai = mem[e_addr[1:0]];
        end
    end

    // Multiplier stand-in: acks each command after a random 1..4 cycles.
    initial begin
        int cnt;
        cnt = 0;
        auto_ack = 1'b0;
        forever begin
            @(negedge clk);
            auto_ack = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) auto_ack = 1'b1;
            end
            if (ack_en && command != 3'b000) cnt = $urandom_range(1, 4);
        end
    end

    // Record every issued command and every RAM read.
    always @(negedge clk) begin
        if (command != 3'b000) cmd_q.push_back(command);
        if (e_rden) rd_q.push_back(e_addr);
    end

    // Reference: left-to-right binary exponentiation over the whole exponent.
    task automatic build_model();
        logic found;
        found = 1'b0;
        exp_cmd_q.delete();
        for (int w = EW - 1; w >= 0; w--) begin
            for (int b = WW - 1; b >= 0; b--) begin
                if (!found) begin
                    if (mem[w][b]) begin
                        found = 1'b1;
                        exp_cmd_q.push_back(C_PRE);
                    end
                end else begin
                    exp_cmd_q.push_back(C_SQR);
                    if (mem[w][b]) exp_cmd_q.push_back(C_MUL);
                end
            end
        end
        if (found) exp_cmd_q.push_back(C_STO);
        exp_zero = !found;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_value({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic compare_streams(input string name);
        check_value({name, "_nreads"}, rd_q.size(), EW);
        for (int i = 0; i < rd_q.size() && i < EW; i++)
            check_value({name, "_raddr"}, {27'd0, rd_q[i]}, EW - 1 - i);
        check_value({name, "_ncmds"}, cmd_q.size(), exp_cmd_q.size());
        for (int i = 0; i < cmd_q.size() && i < exp_cmd_q.size(); i++)
            check_value({name, "_cmd"}, {29'd0, cmd_q[i]}, {29'd0, exp_cmd_q[i]});
    endtask

    // One full exponentiation with automatic acks, checked against the model.
    task automatic run_exp(input string name);
        build_model();
        rd_q.delete();
        cmd_q.delete();
        ack_en = 1'b1;
        pulse_start();
        check_value({name, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(name);
        check_value({name, "_zero"}, {31'd0, zero_exp}, {31'd0, exp_zero});
        @(negedge clk);
        check_value({name, "_pulse"}, {30'd0, done, busy}, 32'd0);
        compare_streams(name);
        $display("run %s: words=%h_%h_%h_%h cmds=%0d exp_cmds=%0d zero=%0b",
                 name, mem[3], mem[2], mem[1], mem[0], cmd_q.size(), exp_cmd_q.size(), exp_zero);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic quiet;
        aclr   = 1'b1;
        start  = 1'b0;
        man_ack = 1'b0;
        ack_en = 1'b0;
        for (int i = 0; i < EW; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_value("reset_outs", {22'd0, busy, done, zero_exp, e_rden, e_addr, command},
                    32'd0);
        aclr = 1'b0;
        @(negedge clk);

        // Directed patterns.
        mem[3] = '0; mem[2] = '0; mem[1] = '0; mem[0] = 27'd5;
        run_exp("exp5");
        mem[0] = 27'd1;
        run_exp("exp1");
        mem[0] = '0;
        run_exp("allzero");
        mem[1] = '0; mem[0] = 27'd3;
        run_exp("exp3");
        mem[3] = 27'h4000001; mem[2] = '0; mem[1] = 27'h7FFFFFF; mem[0] = 27'd1;
        run_exp("edges");

        // Ack withheld: early ack in the issue cycle, start while busy.
        mem[3] = '0; mem[2] = '0; mem[1] = '0; mem[0] = 27'd1;
        build_model();
        rd_q.delete();
        cmd_q.delete();
        ack_en = 1'b0;
        pulse_start();
        n = 0;
        while (command == 3'b000 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_value("hold_first_cmd", {29'd0, command}, {29'd0, C_PRE});
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check_value("hold_cmd_one_cycle", {29'd0, command}, 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 100; i++) begin
            start = (i == 10);
            @(negedge clk);
            if (command != 3'b000 || !busy || e_rden || done) quiet = 1'b0;
        end
        start = 1'b0;
        check_value("hold_quiet", {31'd0, quiet}, 32'd1);
        man_ack = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        wait_done("hold");
        check_value("hold_zero", {31'd0, zero_exp}, 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || e_rden) quiet = 1'b0;
        end
        check_value("hold_no_restart", {31'd0, quiet}, 32'd1);
        compare_streams("hold");
        $display("run hold: early ack ignored, start while busy ignored, cmds=%0d", cmd_q.size());

        // Abort with aclr while waiting for the square's ack.
        mem[0] = 27'd5;
        rd_q.delete();
        cmd_q.delete();
        ack_en = 1'b0;
        pulse_start();
        n = 0;
        while (command == 3'b000 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_value("abort_pre", {29'd0, command}, {29'd0, C_PRE});
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        n = 0;
        while (command == 3'b000 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_value("abort_sqr", {29'd0, command}, {29'd0, C_SQR});
        @(negedge clk);
        aclr = 1'b1;
        #1;
        check_value("abort_outs", {22'd0, busy, done, zero_exp, e_rden, e_addr, command},
                    32'd0);
        @(negedge clk);
        aclr = 1'b0;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (command != 3'b000 || busy || done) quiet = 1'b0;
        end
        check_value("abort_quiet", {31'd0, quiet}, 32'd1);
        check_value("abort_ncmds", cmd_q.size(), 32'd2);
        $display("run abort: cmds before abort=%0d", cmd_q.size());

        // Random exponents, some words forced to zero.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < EW; i++) begin
                if ($urandom_range(0, 2) == 0) mem[i] = '0;
                else if ($urandom_range(0, 1) == 0) mem[i] = WW'($urandom_range(0, 15));
                else mem[i] = WW'($urandom);
            end
            run_exp($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
